branch_predict_resolve: RTL and testbench

BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

---
 rtl/branch_predict_resolve.sv | 60 ++++++
 tb/tb_branch_predict_resolve.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: 2-bit BHT direction predictor with EX-stage branch/jump resolution and redirect
module branch_predict_resolve #(
  parameter int BHT_ENTRIES = 16,
  localparam int IDX_W = $clog2(BHT_ENTRIES)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_fetchPc,
  output logic        o_predTaken,
  input  logic        i_exValid,
  input  logic        i_exIsBranch,
  input  logic        i_exIsJump,
  input  logic [2:0]  i_exFunct3,
  input  logic [31:0] i_exPc,
  input  logic [31:0] i_exTarget,
  input  logic        i_exPredTaken,
  input  logic        i_brLess,
  input  logic        i_brEqual,
  output logic        o_brUnsign,
  output logic        o_flush,
  output logic [31:0] o_redirectPc,
  output logic [31:0] o_branchCount,
  output logic [31:0] o_mispredCount
);
  logic [1:0]       bht [BHT_ENTRIES];
  logic [1:0]       cur, nxt;
  logic [IDX_W-1:0] fidx, uidx;
  logic             cond, br_taken, br_ev, jmp_ev, actual, mis;
  assign fidx = i_fetchPc[IDX_W+1:2];
  assign uidx = i_exPc[IDX_W+1:2];
  assign o_predTaken = bht[fidx][1];
  assign o_brUnsign = i_exFunct3[2:1] == 2'b11;
  assign cond = i_exFunct3[2:1] != 2'b01;
  // funct3[2] picks less vs equal, funct3[0] inverts the sense
  assign br_taken = (i_exFunct3[2] ? i_brLess : i_brEqual) ^ i_exFunct3[0];
  // the slot right after a flush is wrong-path and is dropped
  assign br_ev = i_exValid & ~o_flush & i_exIsBranch & ~i_exIsJump & cond;
  assign jmp_ev = i_exValid & ~o_flush & i_exIsJump;
  assign actual = i_exIsJump | br_taken;
  assign mis = (br_ev | jmp_ev) & (actual != i_exPredTaken);
  assign cur = bht[uidx];
  assign nxt = br_taken ? (cur == 2'b11 ? cur : cur + 2'd1) : (cur == 2'b00 ? cur : cur - 2'd1);
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset)
      for (int k = 0; k < BHT_ENTRIES; k++) bht[k] <= 2'b01;
    else if (br_ev)
      bht[uidx] <= nxt;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      o_flush        <= 1'b0;
      o_redirectPc   <= '0;
      o_branchCount  <= '0;
      o_mispredCount <= '0;
    end else begin
      o_flush <= mis;
      if (mis) o_redirectPc <= actual ? i_exTarget : i_exPc + 32'd4;
      if (br_ev) o_branchCount <= o_branchCount + 32'd1;
      if (mis) o_mispredCount <= o_mispredCount + 32'd1;
    end
endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve: scoreboard bench with an independent BHT/counter reference model
module tb_branch_predict_resolve;
  logic clk = 0, rst = 1;
  logic [31:0] fetch_pc = 0, ex_pc = 0, ex_target = 0;
  logic ex_valid = 0, ex_br = 0, ex_jmp = 0, ex_pt = 0, br_less = 0, br_eq = 0;
  logic [2:0] ex_f3 = 0;
  logic pred_taken, br_unsign, flush;
  logic [31:0] redirect_pc, branch_count, mispred_count;
  always #5 clk = ~clk;
  branch_predict_resolve #(.BHT_ENTRIES(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_fetchPc(fetch_pc), .o_predTaken(pred_taken),
    .i_exValid(ex_valid), .i_exIsBranch(ex_br), .i_exIsJump(ex_jmp), .i_exFunct3(ex_f3),
    .i_exPc(ex_pc), .i_exTarget(ex_target), .i_exPredTaken(ex_pt),
    .i_brLess(br_less), .i_brEqual(br_eq), .o_brUnsign(br_unsign),
    .o_flush(flush), .o_redirectPc(redirect_pc),
    .o_branchCount(branch_count), .o_mispredCount(mispred_count)
  );
  typedef struct {logic fl; logic [31:0] redir, bc, mc;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [1:0] m_bht [16];
  logic m_flush;
  logic [31:0] m_redir, m_bc, m_mc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_bht[k] = 2'b01;
    m_flush = 0; m_redir = 0; m_bc = 0; m_mc = 0;
  endtask
  function automatic logic taken_of(input logic [2:0] f3, input logic less, input logic eq);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return less;
      3'd5, 3'd7: return !less;
      default: return 1'b0;
    endcase
  endfunction
  task automatic step(input logic v, input logic b, input logic j, input logic [2:0] f3,
                      input logic [31:0] pc, input logic [31:0] tgt, input logic pt,
                      input logic less, input logic eq, input logic [31:0] fpc);
    logic ev_b, ev_j, act, mis;
    exp_t e;
    @(negedge clk);
    ex_valid = v; ex_br = b; ex_jmp = j; ex_f3 = f3; ex_pc = pc; ex_target = tgt;
    ex_pt = pt; br_less = less; br_eq = eq; fetch_pc = fpc;
    #1;
    check("pred", pred_taken, m_bht[fpc[5:2]][1]);
    check("unsign", br_unsign, f3 == 3'd6 || f3 == 3'd7);
    ev_b = v && !m_flush && b && !j && f3 != 3'd2 && f3 != 3'd3;
    ev_j = v && !m_flush && j;
    act = j ? 1'b1 : taken_of(f3, less, eq);
    mis = (ev_b || ev_j) && act != pt;
    if (ev_b) begin
      m_bc++;
      if (act && m_bht[pc[5:2]] != 2'b11) m_bht[pc[5:2]]++;
      if (!act && m_bht[pc[5:2]] != 2'b00) m_bht[pc[5:2]]--;
    end
    if (mis) begin
      m_mc++;
      m_redir = act ? tgt : pc + 32'd4;
    end
    m_flush = mis;
    q.push_back('{m_flush, m_redir, m_bc, m_mc});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("flush", flush, e.fl);
    if (e.fl) check("redirect", redirect_pc, e.redir);
    check("branch_count", branch_count, e.bc);
    check("mispred_count", mispred_count, e.mc);
  endtask
  task automatic idle(input logic [31:0] fpc);
    step(0, 0, 0, 3'd2, 0, 0, 0, 0, 0, fpc);
  endtask
  initial begin
    model_reset();
    #2;
    check("rst_flush", flush, 0);
    check("rst_redir", redirect_pc, 0);
    check("rst_bc", branch_count, 0);
    check("rst_mc", mispred_count, 0);
    check("rst_pred", pred_taken, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    // BEQ taken, predicted not-taken
    step(1, 1, 0, 3'd0, 32'h40, 32'h80, 0, 0, 1, 32'h40);
    check("beq_redir", redirect_pc, 32'h80);
    idle(32'h40);
    check("cnt0_msb", pred_taken, 1);
    // BNE not taken, predicted taken
    step(1, 1, 0, 3'd1, 32'h100, 32'h200, 1, 0, 1, 32'h100);
    check("bne_redir", redirect_pc, 32'h104);
    idle(0);
    step(0, 1, 0, 3'd6, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 3'd5, 0, 0, 0, 0, 0, 0);
    // BLT saturation up then down at pc 0x8
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 3'd4, 32'h8, 32'h50, m_bht[2][1], 1, 0, 32'h8);
      idle(32'h8);
    end
    check("sat_hi", m_bht[2], 2'b11);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 3'd4, 32'h8, 32'h50, m_bht[2][1], 0, 0, 32'h8);
      idle(32'h8);
    end
    // back-to-back mispredicts: second lands in the flush slot
    step(1, 1, 0, 3'd0, 32'h20, 32'h60, 0, 0, 1, 32'h20);
    step(1, 1, 0, 3'd0, 32'h24, 32'h64, 0, 0, 1, 32'h24);
    idle(32'h24);
    // same-index update and lookup, then JAL
    step(1, 1, 0, 3'd0, 32'h30, 32'h90, 0, 0, 1, 32'h30);
    idle(32'h30);
    step(1, 0, 1, 3'd0, 32'h200, 32'h300, 0, 0, 0, 32'h200);
    check("jal_redir", redirect_pc, 32'h300);
    idle(32'h200);
    // invalid funct3 branch is inert
    step(1, 1, 0, 3'd2, 32'h44, 32'h88, 1, 1, 1, 32'h44);
    step(1, 1, 0, 3'd3, 32'h44, 32'h88, 1, 1, 1, 32'h44);
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 2);
      step($urandom_range(0, 3) != 0, kind == 1, kind == 2, 3'($urandom_range(0, 7)),
           {$urandom_range(0, 255), 2'b00}, $urandom, $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), {$urandom_range(0, 63), 2'b00});
    end
    // async reset between a mispredict and its edge
    @(negedge clk);
    ex_valid = 1; ex_br = 1; ex_jmp = 0; ex_f3 = 3'd0; ex_pc = 32'h10; ex_target = 32'h70;
    ex_pt = 0; br_eq = 1;
    #2 rst = 1;
    #1;
    model_reset();
    check("arst_flush", flush, 0);
    check("arst_bc", branch_count, 0);
    check("arst_mc", mispred_count, 0);
    @(posedge clk);
    #1;
    check("arst_flush_edge", flush, 0);
    @(negedge clk);
    ex_valid = 0;
    rst = 0;
    for (int k = 0; k < 16; k++) begin
      fetch_pc = k * 4;
      #1;
      check("arst_pred", pred_taken, 0);
    end
    idle(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
